// File: rtl/mcs4.sv
// Shared MCS-4 core types: PC-unit operation codes and stack overflow policy.
package mcs4;

  typedef enum logic [2:0] {
    OpEmit = 3'd0,
    OpInc  = 3'd1,
    OpJun  = 3'd2,
    OpJpg  = 3'd3,
    OpJms  = 3'd4,
    OpBbl  = 3'd5
  } pcop_t;

  typedef enum logic {
    OvfCircular = 1'b0,
    OvfGuarded  = 1'b1
  } ovf_mode_t;

endpackage

// File: rtl/mcs4_nib_ser.sv
// PC nibble serialiser: captures a PC on load and streams it low nibble first.
module mcs4_nib_ser #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  output logic              busy,
  output logic              nib_valid,
  output logic [3:0]        nib_out,
  output logic              nib_last
);

  localparam int unsigned NIB   = ADDR_W / 4;
  localparam int unsigned CNT_W = $clog2(NIB);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [3:0]        out_q, out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] sh_q, sh_d;

  always_comb begin
    busy_d  = busy_q;
    valid_d = valid_q;
    last_d  = last_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    if (load) begin
      busy_d  = 1'b1;
      valid_d = 1'b1;
      out_d   = load_pc[3:0];
      sh_d    = load_pc >> 4;
      cnt_d   = '0;
      last_d  = 1'b0;
    end else if (valid_q) begin
      if (last_q) begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        out_d   = 4'h0;
        cnt_d   = '0;
      end else begin
        cnt_d  = cnt_q + 1'b1;
        out_d  = sh_q[3:0];
        sh_d   = sh_q >> 4;
        last_d = (cnt_d == LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      out_q   <= 4'h0;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
    end
  end

  assign busy      = busy_q;
  assign nib_valid = valid_q;
  assign nib_out   = out_q;
  assign nib_last  = last_q;

endmodule

// File: rtl/mcs4_pc_stack.sv
// Program counter with subroutine stack; every accepted op streams the new PC out as nibbles.
module mcs4_pc_stack
  import mcs4::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PAGE_W   = 8,
  parameter ovf_mode_t   OVF_MODE = OvfCircular
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  pcop_t                      op,
  input  logic [ADDR_W-1:0]          op_addr,
  output logic [ADDR_W-1:0]          pc,
  output logic [$clog2(DEPTH+1)-1:0] stk_lvl,
  output logic                       stk_err,
  input  logic                       err_clr,
  output logic                       nib_valid,
  output logic [3:0]                 nib_out,
  output logic                       nib_last
);

  localparam int unsigned SP_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [ADDR_W-1:0] stack_q [DEPTH];
  logic [ADDR_W-1:0] pc_q, pc_d, pc1;
  logic [SP_W-1:0]   sp_q, sp_d, sp_m1;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic              err_q, err_d, err_set;
  logic              busy, accept, push, full, empty;

  assign accept = op_valid && !busy;
  assign pc1    = pc_q + ADDR_W'(1);
  assign sp_m1  = sp_q - SP_W'(1);
  assign full   = (lvl_q == LVL_FULL);
  assign empty  = (lvl_q == '0);

  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    lvl_d   = lvl_q;
    push    = 1'b0;
    err_set = 1'b0;
    if (accept) begin
      case (op)
        OpInc: pc_d = pc1;
        OpJun: pc_d = op_addr;
        // Page is taken from pc1 so a jump at a page's last byte lands in the next page.
        OpJpg: pc_d = {pc1[ADDR_W-1:PAGE_W], op_addr[PAGE_W-1:0]};
        OpJms: begin
          if (full) err_set = 1'b1;
          if (full && OVF_MODE == OvfGuarded) begin
            pc_d = pc1;
          end else begin
            push = 1'b1;
            sp_d = sp_q + SP_W'(1);
            pc_d = op_addr;
            if (!full) lvl_d = lvl_q + LVL_W'(1);
          end
        end
        OpBbl: begin
          if (empty) err_set = 1'b1;
          if (empty && OVF_MODE == OvfGuarded) begin
            pc_d = pc1;
          end else begin
            sp_d = sp_m1;
            pc_d = stack_q[sp_m1];
            if (!empty) lvl_d = lvl_q - LVL_W'(1);
          end
        end
        default: pc_d = pc_q;
      endcase
    end
    // A fresh error wins over a coincident clear.
    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= '0;
      sp_q  <= '0;
      lvl_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      lvl_q <= lvl_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) stack_q[sp_q] <= pc1;
  end

  mcs4_nib_ser #(
    .ADDR_W(ADDR_W)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_pc  (pc_d),
    .busy     (busy),
    .nib_valid(nib_valid),
    .nib_out  (nib_out),
    .nib_last (nib_last)
  );

  assign op_ready = !busy;
  assign pc       = pc_q;
  assign stk_lvl  = lvl_q;
  assign stk_err  = err_q;

endmodule

// File: tb/tb_mcs4_pc_stack.sv
// Directed bench: a circular 4-deep unit and a guarded 8-deep unit driven from one vector table.
module tb_mcs4_pc_stack;
  import mcs4::*;

  localparam int NIB = 3;

  typedef struct {
    int          sel;
    bit          valid;
    logic [2:0]  op;
    logic [11:0] addr;
    bit          clr;
    logic [11:0] pc;
    int          lvl;
    bit          err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        valid0, clr0, ready0, err0, nv0, nl0;
  pcop_t       op0;
  logic [11:0] addr0, pc0;
  logic [2:0]  lvl0;
  logic [3:0]  no0;
  logic        valid1, clr1, ready1, err1, nv1, nl1;
  pcop_t       op1;
  logic [11:0] addr1, pc1;
  logic [3:0]  lvl1;
  logic [3:0]  no1;

  mcs4_pc_stack #(
    .ADDR_W(12), .DEPTH(4), .PAGE_W(8), .OVF_MODE(OvfCircular)
  ) dut0 (
    .clk(clk), .rst(rst), .op_valid(valid0), .op_ready(ready0), .op(op0), .op_addr(addr0),
    .pc(pc0), .stk_lvl(lvl0), .stk_err(err0), .err_clr(clr0), .nib_valid(nv0),
    .nib_out(no0), .nib_last(nl0)
  );

  mcs4_pc_stack #(
    .ADDR_W(12), .DEPTH(8), .PAGE_W(8), .OVF_MODE(OvfGuarded)
  ) dut1 (
    .clk(clk), .rst(rst), .op_valid(valid1), .op_ready(ready1), .op(op1), .op_addr(addr1),
    .pc(pc1), .stk_lvl(lvl1), .stk_err(err1), .err_clr(clr1), .nib_valid(nv1),
    .nib_out(no1), .nib_last(nl1)
  );

  int          sel;
  logic        r_ready, r_err, r_nv, r_nl;
  logic [11:0] r_pc;
  logic [3:0]  r_lvl, r_no;
  assign r_ready = (sel == 0) ? ready0 : ready1;
  assign r_err   = (sel == 0) ? err0 : err1;
  assign r_nv    = (sel == 0) ? nv0 : nv1;
  assign r_nl    = (sel == 0) ? nl0 : nl1;
  assign r_pc    = (sel == 0) ? pc0 : pc1;
  assign r_lvl   = (sel == 0) ? {1'b0, lvl0} : lvl1;
  assign r_no    = (sel == 0) ? no0 : no1;

  int tests = 0;
  int fails = 0;
  vec_t tbl[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_in(int s, bit v, logic [2:0] o, logic [11:0] a, bit c);
    if (s == 0) begin
      valid0 = v; op0 = pcop_t'(o); addr0 = a; clr0 = c;
    end else begin
      valid1 = v; op1 = pcop_t'(o); addr1 = a; clr1 = c;
    end
  endtask

  task automatic add(int s, bit v, logic [2:0] o, logic [11:0] a, bit c,
                     logic [11:0] p, int l, bit e);
    tbl.push_back('{s, v, o, a, c, p, l, e});
  endtask

  task automatic run(vec_t t);
    logic [11:0] p;
    sel = t.sel;
    p   = t.pc;
    #0;
    chk("ready_before", r_ready, 1);
    set_in(t.sel, t.valid, t.op, t.addr, t.clr);
    @(posedge clk); #1;
    set_in(t.sel, 1'b0, 3'd0, 12'h0, 1'b0);
    chk("pc", r_pc, t.pc);
    chk("stk_lvl", r_lvl, t.lvl);
    chk("stk_err", r_err, t.err);
    if (t.valid) begin
      for (int k = 0; k < NIB; k++) begin
        chk("nib_valid", r_nv, 1);
        chk("nib_out", r_no, p[4*k +: 4]);
        chk("nib_last", r_nl, (k == NIB - 1) ? 1 : 0);
        chk("ready_busy", r_ready, 0);
        @(posedge clk); #1;
      end
    end
    chk("nib_valid_idle", r_nv, 0);
    chk("ready_after", r_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    sel = 0;
    rst = 1'b1;
    set_in(0, 1'b0, 3'd0, 12'h0, 1'b0);
    set_in(1, 1'b0, 3'd0, 12'h0, 1'b0);

    // Circular, depth 4
    add(0, 1, OpJun, 12'hFFF, 0, 12'hFFF, 0, 0);
    add(0, 1, OpInc, 12'h000, 0, 12'h000, 0, 0);
    add(0, 1, OpJun, 12'h2FF, 0, 12'h2FF, 0, 0);
    add(0, 1, OpJpg, 12'h0A5, 0, 12'h3A5, 0, 0);
    add(0, 1, OpJun, 12'h2F0, 0, 12'h2F0, 0, 0);
    add(0, 1, OpJpg, 12'h0A5, 0, 12'h2A5, 0, 0);
    add(0, 1, 3'd6,  12'h777, 0, 12'h2A5, 0, 0);
    add(0, 1, 3'd7,  12'h123, 0, 12'h2A5, 0, 0);
    add(0, 1, OpJun, 12'h100, 0, 12'h100, 0, 0);
    add(0, 1, OpJms, 12'h200, 0, 12'h200, 1, 0);
    add(0, 1, OpJms, 12'h201, 0, 12'h201, 2, 0);
    add(0, 1, OpJms, 12'h202, 0, 12'h202, 3, 0);
    add(0, 1, OpJms, 12'h203, 0, 12'h203, 4, 0);
    add(0, 1, OpJms, 12'h204, 0, 12'h204, 4, 1);  // overwrites 0x101
    add(0, 1, OpBbl, 12'h000, 0, 12'h204, 3, 1);
    add(0, 1, OpBbl, 12'h000, 0, 12'h203, 2, 1);
    add(0, 1, OpBbl, 12'h000, 0, 12'h202, 1, 1);
    add(0, 1, OpBbl, 12'h000, 0, 12'h201, 0, 1);
    add(0, 1, OpBbl, 12'h000, 0, 12'h204, 0, 1);  // underflow returns stale slot 0
    add(0, 0, OpEmit, 12'h000, 1, 12'h204, 0, 0);
    // Guarded, depth 8
    add(1, 1, OpJun, 12'h010, 0, 12'h010, 0, 0);
    add(1, 1, OpBbl, 12'h000, 1, 12'h011, 0, 1);
    add(1, 0, OpEmit, 12'h000, 1, 12'h011, 0, 0);
    for (int i = 0; i < 7; i++) add(1, 1, OpJms, 12'h010 + 12'(i), 0, 12'h010 + 12'(i), i + 1, 0);
    add(1, 1, OpJms, 12'h040, 0, 12'h040, 8, 0);
    add(1, 1, OpJms, 12'h300, 0, 12'h041, 8, 1);
    add(1, 0, OpEmit, 12'h000, 1, 12'h041, 8, 0);
    add(1, 1, OpBbl, 12'h000, 0, 12'h017, 7, 0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #0;
      chk("rst_pc", r_pc, 0);
      chk("rst_lvl", r_lvl, 0);
      chk("rst_err", r_err, 0);
      chk("rst_ready", r_ready, 1);
      chk("rst_nv", r_nv, 0);
      chk("rst_nl", r_nl, 0);
      chk("rst_no", r_no, 0);
    end

    foreach (tbl[i]) run(tbl[i]);

    // Reset on the second nibble aborts the stream; op_valid held throughout.
    sel = 0;
    set_in(0, 1'b1, OpJun, 12'hABC, 1'b0);
    @(posedge clk); #1;
    chk("abort_pc", r_pc, 12'hABC);
    chk("abort_nib0", r_no, 4'hC);
    @(posedge clk); #1;
    chk("abort_nib1", r_no, 4'hB);
    chk("abort_no_reaccept", r_pc, 12'hABC);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_in(0, 1'b0, 3'd0, 12'h0, 1'b0);
    chk("abort_nv", r_nv, 0);
    chk("abort_nl", r_nl, 0);
    chk("abort_pc0", r_pc, 0);
    chk("abort_ready", r_ready, 1);

    // INC held across the whole busy window must be taken once.
    set_in(0, 1'b1, OpInc, 12'h0, 1'b0);
    for (int c = 0; c < NIB + 1; c++) begin
      @(posedge clk); #1;
      chk("hold_pc", r_pc, 12'h001);
    end
    set_in(0, 1'b0, 3'd0, 12'h0, 1'b0);
    chk("hold_ready", r_ready, 1);
    @(posedge clk); #1;
    chk("hold_pc_final", r_pc, 12'h001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
